// File: rtl/memio_axi_hp_bridge_if.sv
// MemIO <-> AXI HP0 signal bundle. The bridge takes the master modport; the
// surrounding Top/PS wiring (or a bench) plays the slave side.
interface memio_axi_hp_bridge_if #(
  parameter int ADDR_BITS = 26,
  parameter int TAG_BITS  = 5,
  parameter int ID_BITS   = 6
);
  logic                 mem_req_cmd_valid;
  logic                 mem_req_cmd_ready;
  logic [ADDR_BITS-1:0] mem_req_cmd_addr;
  logic [TAG_BITS-1:0]  mem_req_cmd_tag;
  logic                 mem_req_cmd_rw;
  logic                 mem_req_data_valid;
  logic                 mem_req_data_ready;
  logic [127:0]         mem_req_data_bits;
  logic                 mem_resp_valid;
  logic                 mem_resp_ready;
  logic [127:0]         mem_resp_data;
  logic [TAG_BITS-1:0]  mem_resp_tag;

  logic                 axi_arvalid;
  logic                 axi_arready;
  logic [31:0]          axi_araddr;
  logic [ID_BITS-1:0]   axi_arid;
  logic                 axi_awvalid;
  logic                 axi_awready;
  logic [31:0]          axi_awaddr;
  logic [ID_BITS-1:0]   axi_awid;
  logic                 axi_wvalid;
  logic                 axi_wready;
  logic [63:0]          axi_wdata;
  logic                 axi_wlast;
  logic                 axi_bvalid;
  logic                 axi_bready;
  logic [1:0]           axi_bresp;
  logic                 axi_rvalid;
  logic                 axi_rready;
  logic [63:0]          axi_rdata;
  logic [ID_BITS-1:0]   axi_rid;
  logic                 axi_rlast;

  logic                 err_bresp;
  logic                 err_rproto;
  logic [2:0]           wr_outstanding;

  modport master (
    input  mem_req_cmd_valid, mem_req_cmd_addr, mem_req_cmd_tag, mem_req_cmd_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_resp_ready,
    input  axi_arready, axi_awready, axi_wready, axi_bvalid, axi_bresp,
    input  axi_rvalid, axi_rdata, axi_rid, axi_rlast,
    output mem_req_cmd_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag,
    output axi_arvalid, axi_araddr, axi_arid, axi_awvalid, axi_awaddr, axi_awid,
    output axi_wvalid, axi_wdata, axi_wlast, axi_bready, axi_rready,
    output err_bresp, err_rproto, wr_outstanding
  );

  modport slave (
    output mem_req_cmd_valid, mem_req_cmd_addr, mem_req_cmd_tag, mem_req_cmd_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_resp_ready,
    output axi_arready, axi_awready, axi_wready, axi_bvalid, axi_bresp,
    output axi_rvalid, axi_rdata, axi_rid, axi_rlast,
    input  mem_req_cmd_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data, mem_resp_tag,
    input  axi_arvalid, axi_araddr, axi_arid, axi_awvalid, axi_awaddr, axi_awid,
    input  axi_wvalid, axi_wdata, axi_wlast, axi_bready, axi_rready,
    input  err_bresp, err_rproto, wr_outstanding
  );
endinterface

// File: rtl/memio_axi_hp_bridge.sv
// Rocket MemIO (128-bit, tagged) to 64-bit AXI HP0 bridge: one 8-beat INCR burst
// per 64-byte block, write-response tracking, read beat pairing with backpressure.
module memio_axi_hp_bridge #(
  parameter int         ADDR_BITS   = 26,
  parameter int         TAG_BITS    = 5,
  parameter int         ID_BITS     = 6,
  parameter logic [3:0] BASE_NIBBLE = 4'h1,
  parameter int         MAX_WR_OUT  = 4
) (
  input logic                   clk,
  input logic                   reset,
  memio_axi_hp_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD_ADDR, WR_ADDR, WR_DATA} state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_WR_OUT);

  state_e              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [2:0]          wr_cnt_q, wr_cnt_d;
  logic                err_b_q, err_b_d;
  logic                err_r_q, err_r_d;
  logic                rphase_q, rphase_d;
  logic [2:0]          rbeat_q, rbeat_d;
  logic                resp_vld_q, resp_vld_d;
  logic [63:0]         lo_q;
  logic [ID_BITS-1:0]  rid_q;
  logic [127:0]        resp_data_q;
  logic [TAG_BITS-1:0] resp_tag_q;

  logic        arvalid, awvalid, wvalid, wlast, cmd_ready, data_ready, rready;
  logic [63:0] wdata;
  logic [31:0] blk_addr;
  logic        aw_hs, w_hs, r_hs;
  logic        unused_addr_hi;

  // Only 22 block-address bits reach the 256 MB HP window.
  assign blk_addr       = {BASE_NIBBLE, bus.mem_req_cmd_addr[21:0], 6'b0};
  assign unused_addr_hi = ^bus.mem_req_cmd_addr[ADDR_BITS-1:22];

  assign aw_hs = awvalid & bus.axi_awready;
  assign w_hs  = wvalid & bus.axi_wready;
  assign r_hs  = bus.axi_rvalid & rready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      wr_cnt_q   <= '0;
      err_b_q    <= 1'b0;
      err_r_q    <= 1'b0;
      rphase_q   <= 1'b0;
      rbeat_q    <= '0;
      resp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wr_cnt_q   <= wr_cnt_d;
      err_b_q    <= err_b_d;
      err_r_q    <= err_r_d;
      rphase_q   <= rphase_d;
      rbeat_q    <= rbeat_d;
      resp_vld_q <= resp_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_cmd_valid && !bus.mem_req_cmd_rw)
          state_d = RD_ADDR;
        else if (bus.mem_req_cmd_valid && bus.mem_req_cmd_rw &&
                 bus.mem_req_data_valid && (wr_cnt_q < MAX_CNT))
          state_d = WR_ADDR;
      end
      RD_ADDR: if (bus.axi_arready) state_d = IDLE;
      WR_ADDR: if (bus.axi_awready) state_d = WR_DATA;
      WR_DATA: if (w_hs && (beat_q == 3'd7)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command is acknowledged only when its address phase completes.
  always_comb begin
    arvalid    = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    wdata      = '0;
    cmd_ready  = 1'b0;
    data_ready = 1'b0;
    case (state_q)
      RD_ADDR: begin
        arvalid   = 1'b1;
        cmd_ready = bus.axi_arready;
      end
      WR_ADDR: begin
        awvalid   = 1'b1;
        cmd_ready = bus.axi_awready;
      end
      WR_DATA: begin
        wvalid     = bus.mem_req_data_valid;
        wdata      = beat_q[0] ? bus.mem_req_data_bits[127:64] : bus.mem_req_data_bits[63:0];
        wlast      = (beat_q == 3'd7);
        data_ready = bus.axi_wready & beat_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_d = beat_q;
    if (aw_hs)
      beat_d = '0;
    else if (w_hs)
      beat_d = beat_q + 3'd1;

    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !bus.axi_bvalid)
      wr_cnt_d = wr_cnt_q + 3'd1;
    else if (!aw_hs && bus.axi_bvalid && (wr_cnt_q != 3'd0))
      wr_cnt_d = wr_cnt_q - 3'd1;

    err_b_d = err_b_q | (bus.axi_bvalid & (bus.axi_bresp != 2'b00));
  end

  // Phase-1 beats stall only while a finished response is still waiting.
  assign rready = !reset & (!rphase_q | !resp_vld_q | bus.mem_resp_ready);

  always_comb begin
    rphase_d   = rphase_q ^ r_hs;
    rbeat_d    = rbeat_q + 3'(r_hs);
    err_r_d    = err_r_q;
    resp_vld_d = resp_vld_q;
    if (r_hs && ((bus.axi_rlast != (rbeat_q == 3'd7)) ||
                 (rphase_q && (bus.axi_rid != rid_q))))
      err_r_d = 1'b1;
    if (r_hs && rphase_q)
      resp_vld_d = 1'b1;
    else if (bus.mem_resp_ready)
      resp_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (r_hs && !rphase_q) begin
      lo_q  <= bus.axi_rdata;
      rid_q <= bus.axi_rid;
    end
    if (r_hs && rphase_q) begin
      resp_data_q <= {bus.axi_rdata, lo_q};
      resp_tag_q  <= bus.axi_rid[TAG_BITS-1:0];
    end
  end

  assign bus.mem_req_cmd_ready  = cmd_ready;
  assign bus.mem_req_data_ready = data_ready;
  assign bus.mem_resp_valid     = resp_vld_q;
  assign bus.mem_resp_data      = resp_vld_q ? resp_data_q : '0;
  assign bus.mem_resp_tag       = resp_vld_q ? resp_tag_q : '0;
  assign bus.axi_arvalid        = arvalid;
  assign bus.axi_araddr         = arvalid ? blk_addr : '0;
  assign bus.axi_arid           = arvalid ? {{(ID_BITS-TAG_BITS){1'b0}}, bus.mem_req_cmd_tag} : '0;
  assign bus.axi_awvalid        = awvalid;
  assign bus.axi_awaddr         = awvalid ? blk_addr : '0;
  assign bus.axi_awid           = '0;
  assign bus.axi_wvalid         = wvalid;
  assign bus.axi_wdata          = wdata;
  assign bus.axi_wlast          = wlast;
  assign bus.axi_bready         = 1'b1;
  assign bus.axi_rready         = rready;
  assign bus.err_bresp          = err_b_q;
  assign bus.err_rproto         = err_r_q;
  assign bus.wr_outstanding     = wr_cnt_q;

endmodule
